div_seq: RTL and testbench
==========================

# div_seq

Iterative 32-bit divide sequencer for the EX stage. It accepts a signed or unsigned DIV/DIVU request from EX and runs a 32-step restoring division. While busy it holds the pipeline with a stall request, then presents a 64-bit {remainder, quotient} result for the HI/LO write path. It owns the only divider in the core, and EX is its sole requester.

## Interface
Parameters:
- none; widths come from `RegBus` / `DoubleRegBus` in defs.v.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low: state is cleared on a clk edge where rst==0.
- signed_div_i  in  1  1 = DIV (two's-complement operands), 0 = DIVU.
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request; EX holds it high until it sees ready_o.
- annul_i  in  1  cancel the in-flight divide (branch/exception flush).
- result_o  out  64  [63:32] remainder, [31:0] quotient; registered.
- ready_o  out  1  result valid; registered.
- stallreq_o  out  1  combinational stall request to the pipeline controller.

## Operation
FSM states (2-bit): FREE, BYZERO, ON, END.
- **FREE**
  - Taken when start_i=1 and annul_i=0.
  - If opdata2_i==0, go to BYZERO.
  - Otherwise go to ON with cnt=0. Latch the divisor as |opdata2_i| when signed_div_i=1, else the raw value. Latch dividend magnitude, both operand signs and signed_div_i.
  - Operand changes after this edge are ignored.
- **BYZERO**
  - Go to END; result register = 0.
- **ON**
  - Taken when annul_i=1: go to FREE immediately and discard state.
  - Else if cnt!=32, perform one restoring step and cnt++:
    - Shift {partial remainder, dividend} left by 1.
    - Compute a 33-bit trial = remainder − divisor.
    - If trial ≥ 0, the remainder takes the trial value and quotient bit = 1; otherwise the remainder is unchanged and the bit = 0.
  - Else (cnt==32), go to END with the sign fix applied:
    - Quotient is negated if signed and sign(op1)^sign(op2).
    - Remainder is negated if signed and sign(op1).
- **END**
  - ready_o=1 and result_o holds its value.
  - When start_i==0, go to FREE, clear ready_o and set result_o=0.
  - annul_i is ignored here.
- annul_i in BYZERO also returns to FREE.
- stallreq_o=1 when any of the following holds:
  - state==FREE with start_i=1 and annul_i=0;
  - state is BYZERO or ON (ON with annul_i=0).
  - In END, stallreq_o=0.
- Arithmetic rules:
  - Magnitudes are 32-bit unsigned; |0x80000000| = 0x80000000.
  - Negation is 32-bit two's complement and wraps.
  - Signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.

## Timing
- Reset values: state=FREE, cnt=0, result_o=0, ready_o=0, stallreq_o=0 (given start_i=0).
- Latency, with edge 0 being the edge where start_i is first sampled in FREE:
  - Nonzero divisor: edges 1..32 are the steps, and edge 33 enters END. ready_o is high from edge 33, i.e. 34 edges after request. stallreq_o is high for those 34 cycles.
  - Divide by zero: BYZERO after edge 0, END after edge 1, ready_o high 2 edges after request.
- ready_o stays high for as long as start_i stays high. It drops on the first edge with start_i==0.
- A new request may be sampled on the cycle after END→FREE.
- start_i staying high in END does not retrigger a divide.
- Reset mid-operation (rst==0 on any edge) forces FREE and zero outputs, regardless of annul_i or start_i.
- Annul in ON:
  - The edge with annul_i=1 moves the FSM to FREE.
  - stallreq_o drops combinationally in that same cycle.
  - ready_o never asserts for that request.
- start_i and annul_i both high in FREE: no request is taken and stallreq_o=0.

## Structure
- defs.v holds the state codes DivFree/DivByZero/DivOn/DivEnd (2'b00..2'b11), plus DivResultReady/NotReady, DivStart/Stop and DoubleRegBus (63:0).
- One sub-module, div_step: a combinational 33-bit trial subtract that returns the next remainder and quotient bit. It keeps the FSM file free of arithmetic.
- cnt is 6 bits, and the dividend/remainder shift register is 65 bits.

## Test plan
- **Unsigned divide:** DIVU 100 / 7 with start held → after 34 edges ready_o=1 and result_o=0x00000002_0000000E. stallreq_o is high for exactly 34 cycles.
- **Signed divide:** DIV 0xFFFFFFF9 (−7) / 2 → result_o=0xFFFFFFFF_FFFFFFFD.
- **Overflow corner:** DIV 0x80000000 / 0xFFFFFFFF → result_o=0x00000000_80000000.
- **Divide by zero:** DIVU 5 / 0 → ready_o=1 after 2 edges with result_o=0. Dropping start_i returns to FREE and clears ready_o.
- **Annul and reset:** annul_i pulsed 10 cycles into ON → FREE next edge, stallreq_o low, no ready_o. A following DIVU 9/3 yields 0x00000000_00000003. Separately, rst=0 during ON → all outputs 0 after that edge.
- **Back-to-back:** two requests with start_i deasserted for one cycle between them → the second result is correct and the first result is not re-presented.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the iterative divide sequencer.
// Widths, FSM state codes and handshake levels used by div_seq and div_step.
package div_seq_pkg;

    localparam int unsigned RegWidth       = 32;
    localparam int unsigned DoubleRegWidth = 64;

    localparam logic [5:0] DivSteps = 6'd32;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's-complement magnitude; 0x80000000 maps onto itself.
    function automatic logic [RegWidth-1:0] mag32(input logic [RegWidth-1:0] v);
        return v[RegWidth-1] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [RegWidth-1:0] neg32(input logic [RegWidth-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the EX stage and the divide sequencer.
// master = EX side, slave = divider side.
interface div_seq_if;
    import div_seq_pkg::*;

    logic                      signed_div_i;
    logic [RegWidth-1:0]       opdata1_i;
    logic [RegWidth-1:0]       opdata2_i;
    logic                      start_i;
    logic                      annul_i;
    logic [DoubleRegWidth-1:0] result_o;
    logic                      ready_o;
    logic                      stallreq_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o,
        input  stallreq_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o,
        output stallreq_o
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, yielding the next remainder and quotient bit.
module div_step
    import div_seq_pkg::*;
(
    input  logic [RegWidth:0]   rem,
    input  logic [RegWidth-1:0] divisor,
    output logic [RegWidth-1:0] rem_next,
    output logic                qbit
);

    logic [RegWidth:0] trial;

    // rem < 2*divisor, so a non-negative trial always fits in 32 bits and a
    // failed trial implies rem itself fits in 32 bits.
    assign trial    = rem - {1'b0, divisor};
    assign qbit     = ~trial[RegWidth];
    assign rem_next = qbit ? trial[RegWidth-1:0] : rem[RegWidth-1:0];

endmodule

// File: rtl/div_seq.sv
// Iterative 32-bit signed/unsigned divide sequencer for the EX stage.
// Runs 32 restoring steps, stalls the pipe while busy, returns {rem, quot}.
module div_seq
    import div_seq_pkg::*;
(
    input logic       clk,
    input logic       rst,
    div_seq_if.slave  bus
);

    div_state_e                state_q;
    logic [5:0]                cnt_q;
    logic [64:0]               shift_q;
    logic [RegWidth-1:0]       divisor_q;
    logic                      signed_q;
    logic                      sign1_q;
    logic                      sign2_q;
    logic [DoubleRegWidth-1:0] result_q;
    logic                      ready_q;

    logic [RegWidth-1:0] step_rem;
    logic                step_qbit;
    logic [RegWidth-1:0] fix_quo;
    logic [RegWidth-1:0] fix_rem;
    logic                req_take;

    // shift_q is kept pre-shifted: [64:32] is the 33-bit trial remainder,
    // quotient bits enter at [0], final remainder ends up in [64:33].
    div_step u_div_step (
        .rem      (shift_q[64:32]),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    assign req_take = (bus.start_i == DivStart) && !bus.annul_i;

    always_comb begin
        fix_quo = shift_q[RegWidth-1:0];
        fix_rem = shift_q[64:33];
        if (signed_q && (sign1_q ^ sign2_q)) begin
            fix_quo = neg32(shift_q[RegWidth-1:0]);
        end
        if (signed_q && sign1_q) begin
            fix_rem = neg32(shift_q[64:33]);
        end
    end

    always_comb begin
        bus.stallreq_o = 1'b0;
        unique case (state_q)
            DivFree:   bus.stallreq_o = req_take;
            DivByZero: bus.stallreq_o = 1'b1;
            DivOn:     bus.stallreq_o = !bus.annul_i;
            DivEnd:    bus.stallreq_o = 1'b0;
            default:   bus.stallreq_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            unique case (state_q)
                DivFree: begin
                    if (req_take) begin
                        if (bus.opdata2_i == '0) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q   <= DivOn;
                            cnt_q     <= '0;
                            signed_q  <= bus.signed_div_i;
                            sign1_q   <= bus.opdata1_i[RegWidth-1];
                            sign2_q   <= bus.opdata2_i[RegWidth-1];
                            divisor_q <= bus.signed_div_i ? mag32(bus.opdata2_i)
                                                          : bus.opdata2_i;
                            shift_q   <= {32'b0,
                                          bus.signed_div_i ? mag32(bus.opdata1_i)
                                                           : bus.opdata1_i,
                                          1'b0};
                        end
                    end
                end
                DivByZero: begin
                    if (bus.annul_i) begin
                        state_q <= DivFree;
                    end else begin
                        state_q  <= DivEnd;
                        result_q <= '0;
                        ready_q  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (bus.annul_i) begin
                        state_q <= DivFree;
                        cnt_q   <= '0;
                    end else if (cnt_q != DivSteps) begin
                        shift_q <= step_qbit ? {step_rem, shift_q[31:0], 1'b1}
                                             : {shift_q[63:0], 1'b0};
                        cnt_q   <= cnt_q + 6'd1;
                    end else begin
                        state_q  <= DivEnd;
                        cnt_q    <= '0;
                        result_q <= {fix_rem, fix_quo};
                        ready_q  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (bus.start_i == DivStop) begin
                        state_q  <= DivFree;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
                    end
                end
                default: state_q <= DivFree;
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: unsigned/signed divides, corner
// cases, divide by zero, annul, mid-run reset and back-to-back requests.
module tb_div_seq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    div_seq_if dif ();

    div_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises a request and waits (bounded) for ready_o; counts edges taken
    // and cycles with stallreq_o high. Optionally scrambles operands after
    // the accepting edge. Leaves start_i high.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input bit scramble, output int edges, output int stalls);
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        dif.annul_i      = 1'b0;
        #1;
        edges  = 0;
        stalls = 0;
        while (!dif.ready_o && edges < 100) begin
            if (dif.stallreq_o) stalls++;
            tick();
            edges++;
            if (scramble && edges == 1) begin
                dif.opdata1_i    = 32'hDEAD_BEEF;
                dif.opdata2_i    = 32'h0;
                dif.signed_div_i = ~sgn;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (dif.ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0", dif.ready_o);
        end
        n_cmp++;
        if (dif.result_o !== 64'h0) begin
            n_err++;
            $display("FAIL reset_result: got %h want 0", dif.result_o);
        end
        n_cmp++;
        if (dif.stallreq_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_stall: got %b want 0", dif.stallreq_o);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        int edges;
        int stalls;
        run_div(1'b0, 32'd100, 32'd7, 1'b1, edges, stalls);
        n_cmp++;
        if (edges !== 34) begin
            n_err++;
            $display("FAIL divu_latency: got %0d edges want 34", edges);
        end
        n_cmp++;
        if (stalls !== 34) begin
            n_err++;
            $display("FAIL divu_stall_cycles: got %0d want 34", stalls);
        end
        n_cmp++;
        if (dif.result_o !== 64'h00000002_0000000E) begin
            n_err++;
            $display("FAIL divu_result: got %h want 000000020000000e", dif.result_o);
        end
        n_cmp++;
        if (dif.stallreq_o !== 1'b0) begin
            n_err++;
            $display("FAIL divu_end_stall: got %b want 0", dif.stallreq_o);
        end
        // Holding start in END must neither retrigger nor drop the result.
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (dif.ready_o !== 1'b1 || dif.result_o !== 64'h00000002_0000000E) begin
            n_err++;
            $display("FAIL divu_hold: got ready=%b result=%h want 1/000000020000000e",
                     dif.ready_o, dif.result_o);
        end
        dif.start_i = 1'b0;
        tick();
        n_cmp++;
        if (dif.ready_o !== 1'b0 || dif.result_o !== 64'h0) begin
            n_err++;
            $display("FAIL divu_drop: got ready=%b result=%h want 0/0",
                     dif.ready_o, dif.result_o);
        end
        // Large divisor exercises the 33-bit partial remainder.
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, edges, stalls);
        n_cmp++;
        if (dif.result_o !== 64'h7FFFFFFE_00000001) begin
            n_err++;
            $display("FAIL divu_big: got %h want 7ffffffe00000001", dif.result_o);
        end
        dif.start_i = 1'b0;
        tick();
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, edges, stalls);
        n_cmp++;
        if (dif.result_o !== 64'h80000000_00000000) begin
            n_err++;
            $display("FAIL divu_min_by_max: got %h want 8000000000000000", dif.result_o);
        end
        dif.start_i = 1'b0;
        tick();
    endtask

    task automatic test_signed();
        int edges;
        int stalls;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, edges, stalls);
        n_cmp++;
        if (dif.result_o !== 64'hFFFFFFFF_FFFFFFFD) begin
            n_err++;
            $display("FAIL div_neg_dividend: got %h want fffffffffffffffd", dif.result_o);
        end
        n_cmp++;
        if (edges !== 34) begin
            n_err++;
            $display("FAIL div_latency: got %0d edges want 34", edges);
        end
        dif.start_i = 1'b0;
        tick();
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, edges, stalls);
        n_cmp++;
        if (dif.result_o !== 64'h00000001_FFFFFFFD) begin
            n_err++;
            $display("FAIL div_neg_divisor: got %h want 00000001fffffffd", dif.result_o);
        end
        dif.start_i = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        int edges;
        int stalls;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, edges, stalls);
        n_cmp++;
        if (dif.result_o !== 64'h00000000_80000000) begin
            n_err++;
            $display("FAIL div_overflow: got %h want 0000000080000000", dif.result_o);
        end
        dif.start_i = 1'b0;
        tick();
    endtask

    task automatic test_byzero();
        int edges;
        int stalls;
        run_div(1'b0, 32'd5, 32'd0, 1'b0, edges, stalls);
        n_cmp++;
        if (edges !== 2 || dif.ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL byzero_latency: got %0d edges ready=%b want 2/1", edges, dif.ready_o);
        end
        n_cmp++;
        if (stalls !== 2) begin
            n_err++;
            $display("FAIL byzero_stall_cycles: got %0d want 2", stalls);
        end
        n_cmp++;
        if (dif.result_o !== 64'h0) begin
            n_err++;
            $display("FAIL byzero_result: got %h want 0", dif.result_o);
        end
        dif.start_i = 1'b0;
        tick();
        n_cmp++;
        if (dif.ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL byzero_drop: got %b want 0", dif.ready_o);
        end
    endtask

    task automatic test_annul();
        int  edges;
        int  stalls;
        logic seen_ready;
        // start+annul together in FREE: nothing is taken.
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd50;
        dif.opdata2_i    = 32'd5;
        dif.start_i      = 1'b1;
        dif.annul_i      = 1'b1;
        #1;
        n_cmp++;
        if (dif.stallreq_o !== 1'b0) begin
            n_err++;
            $display("FAIL free_annul_stall: got %b want 0", dif.stallreq_o);
        end
        tick();
        dif.start_i = 1'b0;
        dif.annul_i = 1'b0;
        #1;
        n_cmp++;
        if (dif.stallreq_o !== 1'b0) begin
            n_err++;
            $display("FAIL free_annul_not_taken: got stall=%b want 0", dif.stallreq_o);
        end
        // Annul 10 cycles into ON.
        dif.opdata1_i = 32'd1000;
        dif.opdata2_i = 32'd3;
        dif.start_i   = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        dif.annul_i = 1'b1;
        dif.start_i = 1'b0;
        #1;
        n_cmp++;
        if (dif.stallreq_o !== 1'b0) begin
            n_err++;
            $display("FAIL annul_stall_comb: got %b want 0", dif.stallreq_o);
        end
        tick();
        dif.annul_i = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dif.ready_o || dif.stallreq_o) seen_ready = 1'b1;
            tick();
        end
        n_cmp++;
        if (seen_ready !== 1'b0) begin
            n_err++;
            $display("FAIL annul_no_ready: got activity=%b want 0", seen_ready);
        end
        run_div(1'b0, 32'd9, 32'd3, 1'b0, edges, stalls);
        n_cmp++;
        if (dif.result_o !== 64'h00000000_00000003 || edges !== 34) begin
            n_err++;
            $display("FAIL after_annul: got %h in %0d edges want 0000000000000003 in 34",
                     dif.result_o, edges);
        end
        dif.start_i = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        int edges;
        int stalls;
        run_div(1'b0, 32'd100, 32'd7, 1'b0, edges, stalls);
        dif.start_i = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd77;
        dif.opdata2_i    = 32'd4;
        tick();
        dif.start_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rst         = 1'b0;
        dif.start_i = 1'b0;
        tick();
        n_cmp++;
        if (dif.ready_o !== 1'b0 || dif.result_o !== 64'h0 || dif.stallreq_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got ready=%b result=%h stall=%b want 0/0/0",
                     dif.ready_o, dif.result_o, dif.stallreq_o);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int edges;
        int stalls;
        run_div(1'b0, 32'd100, 32'd7, 1'b0, edges, stalls);
        dif.start_i = 1'b0;
        tick();
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'hFFFF_FFF9;
        dif.opdata2_i    = 32'd2;
        dif.start_i      = 1'b1;
        tick();
        n_cmp++;
        if (dif.ready_o !== 1'b0 || dif.result_o !== 64'h0) begin
            n_err++;
            $display("FAIL b2b_no_stale: got ready=%b result=%h want 0/0",
                     dif.ready_o, dif.result_o);
        end
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, edges, stalls);
        n_cmp++;
        if (dif.result_o !== 64'h00000001_7FFFFFFC || edges !== 33) begin
            n_err++;
            $display("FAIL b2b_second: got %h in %0d edges want 000000017ffffffc in 33",
                     dif.result_o, edges);
        end
        dif.start_i = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        rst              = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_byzero();
        test_annul();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
